// File: rtl/rs232_rx_fsm.sv
// rs232_rx_fsm - control FSM for an RS232 receiver built around an external
// right-shifting SIPO register.
//
// The FSM synchronizes the serial line, finds the middle of each bit and
// strobes the SIPO once per bit. When the whole frame sits in the SIPO, it
// checks the start, stop and (optionally) parity bits. A good frame updates
// data_o; a bad frame raises an error pulse.
//
// Optional feature macro: RX_PARITY_EN
//   - When defined: an even-parity bit follows the data and the frame is 11 bits.
//   - When undefined: the frame is 10 bits and no parity logic is built.
//
// Parameters
//   BaudDiv     : clk_i cycles per bit (4 or more).
//   FrameW      : frame length in bits (10, or 11 with parity).
//
// Ports
//   clk_i       : clock; all logic runs on the rising edge.
//   rst_i       : asynchronous, active-high reset.
//   rx_i        : asynchronous serial line; idles high.
//   frame_i     : parallel contents of the external SIPO.
//   shift_en_o  : one-cycle shift strobe to the SIPO.
//   sdat_o      : synchronized rx bit, fed to the SIPO serial input.
//   data_o      : last good received byte.
//   rx_done_o   : one-cycle pulse when data_o is updated.
//   frame_err_o : one-cycle pulse on a bad start, stop or parity bit.
//   busy_o      : high whenever the FSM is not idle.
module rs232_rx_fsm #(
    parameter int BaudDiv = 434,
`ifdef RX_PARITY_EN
    parameter int FrameW  = 11
`else
    parameter int FrameW  = 10
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_i,
    input  logic [FrameW-1:0] frame_i,
    output logic              shift_en_o,
    output logic              sdat_o,
    output logic [7:0]        data_o,
    output logic              rx_done_o,
    output logic              frame_err_o,
    output logic              busy_o
);

    localparam int CntW = $clog2(BaudDiv);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntHalf = CntW'(BaudDiv / 2 - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(BaudDiv - 1);
`ifdef RX_PARITY_EN
    localparam logic [3:0] LastBit = 4'd8;   // eight data bits plus parity
`else
    localparam logic [3:0] LastBit = 4'd7;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        CHECK = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      bcnt_q, bcnt_d;
    logic            sync1_q, sync2_q;
    logic [7:0]      data_q, data_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            frame_ok;

    // The frame is good when the start bit is 0, the stop bit is 1 and,
    // if parity is enabled, the parity is even over the data and parity bits.
`ifdef RX_PARITY_EN
    assign frame_ok = ~frame_i[0] & frame_i[FrameW-1] & ~(^frame_i[9:1]);
`else
    assign frame_ok = ~frame_i[0] & frame_i[FrameW-1];
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bcnt_d     = bcnt_q;
        data_d     = data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        shift_en_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!sync2_q) state_d = START;
            end
            // Sample at mid-bit. A line that is high again here was a
            // glitch, so drop it silently.
            START: begin
                cnt_d = cnt_q + CntOne;
                if (cnt_q == CntHalf) begin
                    cnt_d = '0;
                    if (!sync2_q) begin
                        shift_en_o = 1'b1;
                        bcnt_d     = '0;
                        state_d    = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                cnt_d = cnt_q + CntOne;
                if (cnt_q == CntLast) begin
                    shift_en_o = 1'b1;
                    cnt_d      = '0;
                    bcnt_d     = bcnt_q + 4'd1;
                    if (bcnt_q == LastBit) state_d = STOP;
                end
            end
            STOP: begin
                cnt_d = cnt_q + CntOne;
                if (cnt_q == CntLast) begin
                    shift_en_o = 1'b1;
                    cnt_d      = '0;
                    state_d    = CHECK;
                end
            end
            // The SIPO now holds the whole frame. Stay here one cycle only,
            // so a back-to-back start bit is still caught in IDLE.
            CHECK: begin
                state_d = IDLE;
                if (frame_ok) begin
                    data_d = frame_i[8:1];
                    done_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sdat_o      = sync2_q;
    assign data_o      = data_q;
    assign rx_done_o   = done_q;
    assign frame_err_o = err_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_rs232_rx_fsm.sv
// Self-checking bench for rs232_rx_fsm (BaudDiv=16). The bench includes a
// behavioural SIPO, a table of directed frames, hand-written corner-case
// sequences, and randomized frames checked against a simple model of the
// last good byte.
module tb_rs232_rx_fsm;

    localparam int BD = 16;
`ifdef RX_PARITY_EN
    localparam int FW = 11;
`else
    localparam int FW = 10;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic [FW-1:0] sipo = '1;
    logic          shift_en_o, sdat_o, rx_done_o, frame_err_o, busy_o;
    logic [7:0]    data_o;

    rs232_rx_fsm #(.BaudDiv(BD), .FrameW(FW)) dut (
        .clk_i(clk), .rst_i(rst), .rx_i(rx), .frame_i(sipo),
        .shift_en_o(shift_en_o), .sdat_o(sdat_o), .data_o(data_o),
        .rx_done_o(rx_done_o), .frame_err_o(frame_err_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // External right-shifting SIPO: new bit enters at the MSB.
    always @(posedge clk) if (shift_en_o) sipo <= {sdat_o, sipo[FW-1:1]};

    // Event monitor, sampled on the falling edge.
    int n_shift = 0, n_done = 0, n_err = 0, n_both = 0, n_busy = 0;
    logic [7:0] done_q[$];
    always @(negedge clk) if (!rst) begin
        if (shift_en_o) n_shift <= n_shift + 1;
        if (rx_done_o) begin
            n_done <= n_done + 1;
            done_q.push_back(data_o);
        end
        if (frame_err_o) n_err <= n_err + 1;
        if (rx_done_o && frame_err_o) n_both <= n_both + 1;
        if (busy_o) n_busy <= n_busy + 1;
    end

    int vecs = 0, miscompares = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BD) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic pflip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef RX_PARITY_EN
        send_bit((^d) ^ pflip);
`else
        if (pflip) begin end
`endif
        send_bit(stop_b);
    endtask

    task automatic run_frame(input string nm, input logic [7:0] d, input logic stop_b,
                             input logic pflip, input int exp_done, input int exp_err,
                             input logic [7:0] exp_data);
        int s0, d0, e0;
        s0 = n_shift; d0 = n_done; e0 = n_err;
        send_frame(d, stop_b, pflip);
        idle(24);
        check({nm, "_shifts"}, n_shift - s0, FW);
        check({nm, "_done"},   n_done - d0,  exp_done);
        check({nm, "_err"},    n_err - e0,   exp_err);
        check({nm, "_data"},   data_o,       exp_data);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop_b;
        int         exp_done;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[6];
    logic [7:0] last_good;

    initial begin
        int s0, d0, e0, b0, q0;
        logic [7:0] v0, v1;

        tbl[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        tbl[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
        tbl[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
        tbl[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        tbl[4] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
        tbl[5] = '{8'h81, 1'b0, 0, 1, 8'h3C};

        // Reset state
        rst = 1'b1; rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_shift", shift_en_o, 0);
        check("rst_sdat",  sdat_o, 1);
        check("rst_data",  data_o, 0);
        check("rst_done",  rx_done_o, 0);
        check("rst_err",   frame_err_o, 0);
        check("rst_busy",  busy_o, 0);
        rst = 1'b0;
        idle(20);

        // Directed table
        for (int i = 0; i < 6; i++)
            run_frame($sformatf("tbl%0d", i), tbl[i].d, tbl[i].stop_b, 1'b0,
                      tbl[i].exp_done, tbl[i].exp_err, tbl[i].exp_data);

        // Start-bit glitch: 4 clocks low
        s0 = n_shift; d0 = n_done; e0 = n_err; b0 = n_busy;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(30);
        check("glitch_shifts", n_shift - s0, 0);
        check("glitch_done",   n_done - d0, 0);
        check("glitch_err",    n_err - e0, 0);
        check("glitch_busy_len", (n_busy - b0 > 0) && (n_busy - b0 <= 9), 1);
        check("glitch_busy",   busy_o, 0);

        // Back-to-back frames 0x00 then 0xFF
        s0 = n_shift; d0 = n_done; e0 = n_err; q0 = done_q.size();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(24);
        check("b2b_shifts", n_shift - s0, 2 * FW);
        check("b2b_done",   n_done - d0, 2);
        check("b2b_err",    n_err - e0, 0);
        v0 = (done_q.size() > q0)     ? done_q[q0]     : 8'hxx;
        v1 = (done_q.size() > q0 + 1) ? done_q[q0 + 1] : 8'hxx;
        check("b2b_first",  v0, 8'h00);
        check("b2b_second", v1, 8'hFF);

        // Reset during data bit 4 of 0x55, then a clean frame 0x81
        d0 = n_done; e0 = n_err;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1 & (8'h55 >> i));
        rx = 1'b1;                     // bit 4 of 0x55 is 1
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(40);
        check("rstmid_done", n_done - d0, 0);
        check("rstmid_err",  n_err - e0, 0);
        check("rstmid_data", data_o, 0);
        check("rstmid_busy", busy_o, 0);
        run_frame("after_rst", 8'h81, 1'b1, 1'b0, 1, 0, 8'h81);
        last_good = 8'h81;

`ifdef RX_PARITY_EN
        run_frame("par_ok",  8'h07, 1'b1, 1'b0, 1, 0, 8'h07);
        run_frame("par_bad", 8'h07, 1'b1, 1'b1, 0, 1, 8'h07);
        last_good = 8'h07;
`endif

        // Randomized frames against the last-good-byte model
        for (int i = 0; i < 20; i++) begin
            logic [7:0] d;
            logic       stop_b, pflip, good;
            d      = 8'($urandom);
            stop_b = ($urandom_range(3) != 0);
`ifdef RX_PARITY_EN
            pflip  = ($urandom_range(4) == 0);
`else
            pflip  = 1'b0;
`endif
            good = stop_b && !pflip;
            if (good) last_good = d;
            run_frame($sformatf("rand%0d", i), d, stop_b, pflip,
                      good ? 1 : 0, good ? 0 : 1, last_good);
        end

        check("never_both", n_both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule

// File: doc/rs232_rx_fsm.md
RS232_RX_FSM -- requirements
Module: rs232_rx_fsm

Interface
REQ-001 SHALL have parameter BaudDiv, default 434 (50 MHz / 115200), meaning clk_i cycles per bit; legal range 4 or more.
REQ-002 SHALL have parameter FrameW, default 10, meaning the frame length in bits; it SHALL be forced to 11 when RX_PARITY_EN is defined.
REQ-003 SHALL have clk_i, input, 1 bit: clock; all logic on the rising edge.
REQ-004 SHALL have rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have rx_i, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have frame_i, input, FrameW bits: parallel output of the external right-shifting SIPO register.
REQ-007 SHALL have shift_en_o, output, 1 bit: one-cycle shift enable to the SIPO.
REQ-008 SHALL have sdat_o, output, 1 bit: synchronized rx bit to the SIPO serial input.
REQ-009 SHALL have data_o, output, 8 bits: last good received byte.
REQ-010 SHALL have rx_done_o, output, 1 bit: one-cycle pulse when data_o is updated.
REQ-011 SHALL have frame_err_o, output, 1 bit: one-cycle pulse on a bad start, stop or parity bit.
REQ-012 SHALL have busy_o, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 SHALL pass rx_i through a 2-flop synchronizer; sdat_o is the second flop.
REQ-014 SHALL implement the states IDLE, START, DATA, STOP and CHECK; one counter cnt runs $clog2(BaudDiv) bits wide and a bit counter bcnt runs 0..7 (0..8 with parity).
REQ-015 In IDLE, sdat_o==0 SHALL move to START with cnt=0; otherwise the block stays in IDLE.
REQ-016 In START, cnt SHALL increment; at cnt==BaudDiv/2-1, sdat_o==0 SHALL give a shift_en_o pulse and move to DATA with cnt=0, bcnt=0.
REQ-017 In START, sdat_o==1 at that sample point SHALL be treated as a glitch: return to IDLE, no shift_en_o, no error.
REQ-018 In DATA, cnt SHALL increment; at cnt==BaudDiv-1 the block SHALL pulse shift_en_o, set cnt=0 and increment bcnt.
REQ-019 After the last data bit (bcnt 7, or 8 with parity), DATA SHALL move to STOP.
REQ-020 In STOP, cnt SHALL increment; at cnt==BaudDiv-1 the block SHALL pulse shift_en_o and move to CHECK.
REQ-021 A frame SHALL produce exactly FrameW shift_en_o pulses, spaced BaudDiv cycles apart after the first.
REQ-022 CHECK SHALL last one cycle, then go to IDLE; the SIPO holds the full frame here, with frame_i[0]=start, [8:1]=data LSB first, [FrameW-1]=stop.
REQ-023 In CHECK, if frame_i[0]==0, frame_i[FrameW-1]==1 and parity is OK, the block SHALL register data_o<=frame_i[8:1] and pulse rx_done_o the next cycle.
REQ-024 On any failed check in CHECK, the block SHALL pulse frame_err_o the next cycle and leave data_o unchanged.
REQ-025 rx_done_o and frame_err_o SHALL never be high in the same cycle.
REQ-026 A new start bit SHALL be accepted in the cycle after CHECK, so back-to-back frames with no extra idle time are received.
REQ-027 rx_i activity outside IDLE SHALL be ignored except at sample points.

Reset
REQ-028 rst_i high SHALL force state IDLE, cnt=0, bcnt=0, both synchronizer flops=1, shift_en_o=0, data_o=0, rx_done_o=0, frame_err_o=0, busy_o=0.
REQ-029 A reset asserted mid-frame SHALL abandon the frame with no rx_done_o or frame_err_o; after reset release, reception restarts only on a new falling edge.

Configuration
REQ-030 Macro RX_PARITY_EN defined: FrameW=11, frame_i[9] is even parity over frame_i[8:1], a mismatch fails the check in CHECK, and there are 11 shifts per frame.
REQ-031 Macro RX_PARITY_EN undefined: FrameW=10, no parity logic is present, and there are 10 shifts per frame.

Verification (BaudDiv=16, sipo_reg_rx Width=FrameW, 1 bit = 16 clocks)
REQ-032 Frame 0xA5 (start 0, data LSB first, stop 1) -> 10 shift_en_o pulses; rx_done_o pulses once; data_o=0xA5; frame_err_o stays 0.
REQ-033 Frame 0x3C with the stop bit driven 0 -> frame_err_o pulses once; no rx_done_o; data_o keeps its previous value.
REQ-034 rx_i low for 4 clocks then high -> 0 shift_en_o pulses; busy_o returns to 0 within 9 cycles; no rx_done_o or frame_err_o.
REQ-035 Back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_done_o pulses, with data_o=0x00 then 0xFF.
REQ-036 rst_i pulse during data bit 4 of frame 0x55, then a clean frame 0x81 -> no output pulse for the first frame; data_o=0x81 after the second.
REQ-037 With RX_PARITY_EN, 0x07 sent with parity 1 -> rx_done_o; 0x07 sent with parity 0 -> frame_err_o.
